// File: rtl/miriscv_irq_pkg.sv
// Shared types and constants for the miriscv interrupt controller.
package miriscv_irq_pkg;

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        SERVE = 2'd1,
        FIN   = 2'd2
    } irq_state_t;

    localparam logic [31:0] IRQ_CAUSE_BASE = 32'h8000_0010;
    localparam int          IRQ_MAX        = 32;

    // mcause for a served line: base plus the zero-extended line number
    function automatic logic [31:0] irq_cause(input logic [4:0] line);
        return IRQ_CAUSE_BASE + {27'd0, line};
    endfunction

endpackage

// File: rtl/miriscv_irq_ctrl.sv
// Round-robin interrupt controller: scans mie-qualified requests, raises one
// interrupt with its mcause, and acknowledges the served line after mret.
module miriscv_irq_ctrl
    import miriscv_irq_pkg::*;
#(
    parameter int N_IRQ = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [N_IRQ-1:0] int_req_i,
    input  logic [N_IRQ-1:0] mie_i,
    input  logic             irq_ret_i,
    output logic             irq_o,
    output logic [31:0]      irq_cause_o,
    output logic [N_IRQ-1:0] int_fin_o
);

    localparam int               IDX_W    = $clog2(N_IRQ);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IRQ - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(1'b0);
    localparam logic [N_IRQ-1:0] FIN_ONE  = N_IRQ'(1'b1);

    irq_state_t       state_r, state_n;
    logic [IDX_W-1:0] idx_r, idx_n;
    logic [IDX_W-1:0] srv_r, srv_n;
    logic             irq_r, irq_n;
    logic [31:0]      cause_r, cause_n;
    logic [N_IRQ-1:0] fin_r, fin_n;
    logic             hit_s;

    // Explicit wrap keeps non-power-of-two N_IRQ inside the request vector
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        if (v == IDX_LAST) begin
            return IDX_ZERO;
        end else begin
            return v + IDX_ONE;
        end
    endfunction

    assign hit_s = int_req_i[idx_r] & mie_i[idx_r];

    // Next-state, scan pointer and next output register values
    always_comb begin
        state_n = state_r;
        idx_n   = idx_r;
        srv_n   = srv_r;
        irq_n   = 1'b0;
        cause_n = 32'h0000_0000;
        fin_n   = {N_IRQ{1'b0}};

        case (state_r)
            SCAN: begin
                if (hit_s) begin
                    srv_n   = idx_r;
                    state_n = SERVE;
                end else begin
                    idx_n   = wrap_inc(idx_r);
                end
            end
            SERVE: begin
                if (irq_ret_i) begin
                    state_n = FIN;
                end else begin
                    state_n = SERVE;
                end
            end
            FIN: begin
                // Resume just past the served line so every other line goes first
                idx_n   = wrap_inc(srv_r);
                state_n = SCAN;
            end
            default: begin
                idx_n   = IDX_ZERO;
                state_n = SCAN;
            end
        endcase

        if (state_n == SERVE) begin
            irq_n   = 1'b1;
            cause_n = irq_cause(5'(srv_n));
        end else begin
            irq_n   = 1'b0;
            cause_n = 32'h0000_0000;
        end

        if (state_n == FIN) begin
            fin_n = FIN_ONE << srv_r;
        end else begin
            fin_n = {N_IRQ{1'b0}};
        end
    end

    // State, pointers and registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= SCAN;
            idx_r   <= IDX_ZERO;
            srv_r   <= IDX_ZERO;
            irq_r   <= 1'b0;
            cause_r <= 32'h0000_0000;
            fin_r   <= {N_IRQ{1'b0}};
        end else begin
            state_r <= state_n;
            idx_r   <= idx_n;
            srv_r   <= srv_n;
            irq_r   <= irq_n;
            cause_r <= cause_n;
            fin_r   <= fin_n;
        end
    end

    assign irq_o       = irq_r;
    assign irq_cause_o = cause_r;
    assign int_fin_o   = fin_r;

endmodule
